// File: rtl/audio_tone_gen.sv
// rtl/audio_tone_gen.sv - multi-channel sample-rate tone generator; optional saturating mixer via AUDIO_TONE_MIX_EN
`timescale 1ns/1ps

module audio_tone_gen #(
    parameter int CHANNELS       = 2,
    parameter int BIT_WIDTH      = 16,
    parameter int PHASE_WIDTH    = 24,
    parameter int PIXEL_CLOCK_HZ = 74250000,
    parameter int SAMPLE_RATE    = 48000
) (
    input  logic                              clk_pixel,
    input  logic                              reset_n,
    input  logic [CHANNELS-1:0]               enable,
    input  logic [2*CHANNELS-1:0]             waveform_sel,
    input  logic [PHASE_WIDTH*CHANNELS-1:0]   phase_inc,
    input  logic [4*CHANNELS-1:0]             atten,
    output logic                              audio_tick,
    output logic                              sample_valid,
    output logic [BIT_WIDTH*CHANNELS-1:0]     samples,
    output logic [BIT_WIDTH-1:0]              mix_sample
);

    localparam int BW    = BIT_WIDTH;
    localparam int PW    = PHASE_WIDTH;
    localparam int ACC_W = $clog2(PIXEL_CLOCK_HZ) + 1;

    localparam logic [ACC_W-1:0] C_RATE = ACC_W'(SAMPLE_RATE);
    localparam logic [ACC_W-1:0] C_PCLK = ACC_W'(PIXEL_CLOCK_HZ);

    // Full-scale square levels are symmetric, so the negative level is -(2^(BW-1)-1)
    localparam logic signed [BW-1:0] C_POS_FULL = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] C_NEG_FULL = {1'b1, {(BW-2){1'b0}}, 1'b1};

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_sum;
    logic             r_valid;

`ifdef AUDIO_TONE_MIX_EN
    logic [BW*CHANNELS-1:0] w_next_bus;
`endif

    // Tick is decided from the current accumulator so it needs no extra register stage
    assign w_acc_sum  = r_acc + C_RATE;
    assign audio_tick = (w_acc_sum >= C_PCLK);

    // Fractional rate accumulator: keeps the remainder so the long-run rate is exact
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (audio_tick) begin
            r_acc <= w_acc_sum - C_PCLK;
        end else begin
            r_acc <= w_acc_sum;
        end
    end

    // Valid strobe trails the tick by one cycle, when the new samples are visible
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= audio_tick;
        end
    end

    assign sample_valid = r_valid;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [PW-1:0]        r_phase;
        logic [PW-1:0]        w_phase_next;
        logic [BW-1:0]        w_top;
        logic [BW-1:0]        w_sub;
        logic [BW-1:0]        w_tri;
        logic [1:0]           w_sel;
        logic [3:0]           w_att;
        logic signed [BW-1:0] w_wave;
        logic signed [BW-1:0] w_shaped;
        logic signed [BW-1:0] r_sample;

        assign w_sel        = waveform_sel[2*g +: 2];
        assign w_att        = atten[4*g +: 4];
        assign w_phase_next = r_phase + phase_inc[g*PW +: PW];
        assign w_top        = w_phase_next[PW-1 -: BW];
        assign w_sub        = w_phase_next[PW-2 -: BW];
        assign w_tri        = w_phase_next[PW-1] ? ~w_sub : w_sub;

        // Waveform shaping from the advanced phase; MSB inversion converts offset-binary to signed
        always_comb begin
            w_wave = '0;
            case (w_sel)
                2'b00:   w_wave = {~w_top[BW-1], w_top[BW-2:0]};
                2'b01:   w_wave = w_phase_next[PW-1] ? C_NEG_FULL : C_POS_FULL;
                2'b10:   w_wave = {~w_tri[BW-1], w_tri[BW-2:0]};
                default: w_wave = '0;
            endcase
        end

        assign w_shaped = w_wave >>> w_att;

`ifdef AUDIO_TONE_MIX_EN
        assign w_next_bus[g*BW +: BW] = enable[g] ? w_shaped : '0;
`endif

        // Phase and sample only move on a tick; a disabled channel restarts from zero phase
        always_ff @(posedge clk_pixel or negedge reset_n) begin
            if (!reset_n) begin
                r_phase  <= '0;
                r_sample <= '0;
            end else if (audio_tick) begin
                if (enable[g]) begin
                    r_phase  <= w_phase_next;
                    r_sample <= w_shaped;
                end else begin
                    r_phase  <= '0;
                    r_sample <= '0;
                end
            end
        end

        assign samples[g*BW +: BW] = r_sample;
    end

`ifdef AUDIO_TONE_MIX_EN
    localparam int MW = BW + $clog2(CHANNELS);
    localparam logic signed [MW-1:0] C_MIX_MAX = MW'({1'b0, {(BW-1){1'b1}}});
    localparam logic signed [MW-1:0] C_MIX_MIN = {{(MW-BW+1){1'b1}}, {(BW-1){1'b0}}};

    logic signed [MW-1:0] w_mix_sum;
    logic [BW-1:0]        w_mix_sat;
    logic [BW-1:0]        r_mix;

    // Sum the samples about to be registered, widened so the sum itself cannot overflow
    always_comb begin
        w_mix_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_mix_sum = w_mix_sum + MW'($signed(w_next_bus[i*BW +: BW]));
        end
    end

    // Clamp the wide sum back into the output sample range
    always_comb begin
        w_mix_sat = w_mix_sum[BW-1:0];
        if (w_mix_sum > C_MIX_MAX) begin
            w_mix_sat = {1'b0, {(BW-1){1'b1}}};
        end else if (w_mix_sum < C_MIX_MIN) begin
            w_mix_sat = {1'b1, {(BW-1){1'b0}}};
        end
    end

    // Mix register shares the tick edge with the per-channel samples
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_mix <= '0;
        end else if (audio_tick) begin
            r_mix <= w_mix_sat;
        end
    end

    assign mix_sample = r_mix;
`else
    assign mix_sample = '0;
`endif

endmodule
